// File: rtl/pipe_ctrl_n.sv
// Parametrised pipeline sequencer: per-stage valid tracking, hold chain, halt/drain,
// saturating stall-cycle counter and sticky per-stage extend watchdogs.
module pipe_ctrl_n #(
  parameter int unsigned STAGES     = 5,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned MAX_EXTEND = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stall,
  input  logic [STAGES-1:0] extend,
  input  logic [STAGES-1:0] flush,
  input  logic              halt,
  output logic [STAGES-1:0] keep,
  output logic [STAGES-1:0] dirty,
  output logic              empty,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [STAGES-1:0] timeout
);

  localparam int unsigned       EXT_W   = $clog2(MAX_EXTEND + 1);
  localparam logic [EXT_W-1:0]  EXT_MAX = EXT_W'(MAX_EXTEND);
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

  logic [STAGES-1:0] hold;
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] v_nxt;
  logic [EXT_W-1:0]  ext_cnt [STAGES];

  // Back-pressure: a held stage holds every earlier (higher-index) stage too.
  always_comb begin
    hold    = '0;
    hold[0] = stall[0] | extend[0];
    for (int i = 1; i < STAGES; i++) begin
      hold[i] = stall[i] | extend[i] | hold[i-1];
    end
  end

  assign keep  = hold | {halt, {(STAGES-1){1'b0}}};
  assign dirty = ~v;
  assign empty = &dirty;

  // Flush beats hold; a bubble enters directly below the lowest held stage.
  always_comb begin
    v_nxt = v;
    if (flush[STAGES-1])     v_nxt[STAGES-1] = 1'b0;
    else if (!hold[STAGES-1]) v_nxt[STAGES-1] = ~halt;
    for (int i = 0; i < STAGES - 1; i++) begin
      if (flush[i])      v_nxt[i] = 1'b0;
      else if (!hold[i]) v_nxt[i] = v[i+1] & ~hold[i+1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) v <= '0;
    else     v <= v_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (keep[STAGES-1] && !halt && stall_cycles != CNT_MAX) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

  // Watchdog: timeout latches on the edge the consecutive-extend count reaches the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout <= '0;
      for (int i = 0; i < STAGES; i++) ext_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (extend[i]) begin
          if (ext_cnt[i] != EXT_MAX) ext_cnt[i] <= ext_cnt[i] + EXT_W'(1);
          if (ext_cnt[i] >= EXT_MAX - EXT_W'(1)) timeout[i] <= 1'b1;
        end else begin
          ext_cnt[i] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_n.sv
// Directed self-checking bench for pipe_ctrl_n (STAGES=5, CNT_W=16, MAX_EXTEND=4).
module tb_pipe_ctrl_n;

  localparam int unsigned STAGES = 5;
  localparam int unsigned CNT_W  = 16;

  logic              clk;
  logic              rst;
  logic [STAGES-1:0] stall, extend, flush;
  logic              halt;
  logic [STAGES-1:0] keep, dirty, timeout;
  logic              empty;
  logic [CNT_W-1:0]  stall_cycles;

  int n_checks = 0;
  int n_pass   = 0;

  pipe_ctrl_n #(.STAGES(STAGES), .CNT_W(CNT_W), .MAX_EXTEND(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .extend(extend), .flush(flush),
    .halt(halt), .keep(keep), .dirty(dirty), .empty(empty),
    .stall_cycles(stall_cycles), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [STAGES-1:0] fill_seq [6];

  initial begin
    fill_seq[0] = 5'b11111; fill_seq[1] = 5'b01111; fill_seq[2] = 5'b00111;
    fill_seq[3] = 5'b00011; fill_seq[4] = 5'b00001; fill_seq[5] = 5'b00000;

    rst = 1'b1; stall = '0; extend = '0; flush = '0; halt = 1'b0;
    #3;
    check_eq("rst_dirty", 32'(dirty), 32'h1f);
    check_eq("rst_empty", 32'(empty), 32'h1);
    check_eq("rst_cnt", 32'(stall_cycles), 32'h0);
    check_eq("rst_timeout", 32'(timeout), 32'h0);
    stall = 5'b00100;
    #1;
    check_eq("rst_keep_comb", 32'(keep), 32'h1c);
    stall = '0;
    tick();
    rst = 1'b0;

    // Fill from reset
    for (int k = 0; k < 6; k++) begin
      check_eq($sformatf("fill_dirty%0d", k), 32'(dirty), 32'(fill_seq[k]));
      check_eq($sformatf("fill_keep%0d", k), 32'(keep), 32'h0);
      if (k == 1) check_eq("fill_empty_low", 32'(empty), 32'h0);
      if (k < 5) tick();
    end

    // stall[3] for two cycles
    stall = 5'b01000;
    #1 check_eq("stall_keep1", 32'(keep), 32'h18);
    tick();
    check_eq("stall_dirty1", 32'(dirty), 32'h04);
    check_eq("stall_keep2", 32'(keep), 32'h18);
    tick();
    check_eq("stall_dirty2", 32'(dirty), 32'h06);
    check_eq("stall_cnt", 32'(stall_cycles), 32'd2);
    stall = '0;
    tick(); check_eq("refill1", 32'(dirty), 32'h03);
    tick(); check_eq("refill2", 32'(dirty), 32'h01);
    tick(); check_eq("refill3", 32'(dirty), 32'h00);

    // flush[4:3] together with stall[3]
    flush = 5'b11000; stall = 5'b01000;
    #1 check_eq("flush_keep", 32'(keep), 32'h18);
    tick();
    check_eq("flush_dirty", 32'(dirty), 32'h1c);
    check_eq("flush_cnt", 32'(stall_cycles), 32'd3);
    flush = '0; stall = '0;
    tick(); check_eq("post_flush1", 32'(dirty), 32'h0e);
    repeat (4) tick();
    check_eq("post_flush_full", 32'(dirty), 32'h00);

    // halt / drain
    halt = 1'b1;
    #1 check_eq("halt_keep", 32'(keep), 32'h10);
    tick(); check_eq("drain1", 32'(dirty), 32'h10);
    tick(); check_eq("drain2", 32'(dirty), 32'h18);
    tick(); check_eq("drain3", 32'(dirty), 32'h1c);
    tick(); check_eq("drain4", 32'(dirty), 32'h1e);
    check_eq("drain_not_empty", 32'(empty), 32'h0);
    tick(); check_eq("drain5", 32'(dirty), 32'h1f);
    check_eq("drain_empty", 32'(empty), 32'h1);
    check_eq("halt_cnt", 32'(stall_cycles), 32'd3);
    halt = 1'b0;
    #1 check_eq("unhalt_keep", 32'(keep), 32'h00);
    tick(); check_eq("unhalt_dirty", 32'(dirty), 32'h0f);
    repeat (4) tick();
    check_eq("unhalt_full", 32'(dirty), 32'h00);

    // extend[2] for 3 cycles: no timeout
    extend = 5'b00100;
    #1 check_eq("ext_keep", 32'(keep), 32'h1c);
    repeat (3) tick();
    check_eq("ext3_timeout", 32'(timeout), 32'h0);
    extend = '0;
    tick(); check_eq("ext3_after", 32'(timeout), 32'h0);

    // extend[2] for 4 cycles: trips on the 4th edge and sticks
    extend = 5'b00100;
    repeat (3) tick();
    check_eq("ext4_pre", 32'(timeout), 32'h0);
    tick(); check_eq("ext4_trip", 32'(timeout), 32'h04);
    extend = '0;
    tick(); check_eq("ext4_sticky", 32'(timeout), 32'h04);
    check_eq("ext_cnt", 32'(stall_cycles), 32'd10);
    repeat (5) tick();
    check_eq("ext_refill", 32'(dirty), 32'h00);

    // Long stall[4]: counter saturates
    stall = 5'b10000;
    repeat (65525) tick();
    check_eq("cnt_at_max", 32'(stall_cycles), 32'd65535);
    repeat (4475) tick();
    check_eq("cnt_saturated", 32'(stall_cycles), 32'd65535);

    // Asynchronous reset mid-stall
    #2 rst = 1'b1;
    #1;
    check_eq("arst_dirty", 32'(dirty), 32'h1f);
    check_eq("arst_cnt", 32'(stall_cycles), 32'h0);
    check_eq("arst_empty", 32'(empty), 32'h1);
    check_eq("arst_timeout", 32'(timeout), 32'h0);
    check_eq("arst_keep", 32'(keep), 32'h10);
    stall = '0;
    tick();
    rst = 1'b0;
    tick(); check_eq("rerelease", 32'(dirty), 32'h0f);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
